mem_req_adapter: RTL and testbench

//  Single-clock front end for one port of the dual-port masked simulation RAM (SimMemMask).

---
 rtl/mem_req_adapter.sv | 98 +++++++++
 tb/tb_mem_req_adapter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_adapter.sv
// mem_req_adapter: valid/ready request front end for one port of the masked simulation RAM.
// Issues reads only against free response-FIFO credits, tracks fixed RAM latency, buffers read data.
module mem_req_adapter #(
  parameter int WIDTH     = 16,
  parameter int LENGTH    = 32,
  parameter int DELAY     = 1,
  parameter int MASK      = 2,
  parameter int RSP_DEPTH = 4,
  localparam int AW       = $clog2(LENGTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             reqValid_i,
  output logic             reqReady_o,
  input  logic             reqWrite_i,
  input  logic [AW-1:0]    reqAddr_i,
  input  logic [MASK-1:0]  reqMask_i,
  input  logic [WIDTH-1:0] reqData_i,
  output logic             rspValid_o,
  input  logic             rspReady_i,
  output logic [WIDTH-1:0] rspData_o,
  output logic             memEn_o,
  output logic [MASK-1:0]  memWr_o,
  output logic [AW-1:0]    memAddr_o,
  output logic [WIDTH-1:0] memData_o,
  input  logic [WIDTH-1:0] memData_i,
  output logic             busy_o
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DELAY-1:0] rdPipe;
  logic [DELAY:0]   pipeExt;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    fifoCount;
  logic [CW:0]      pending;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [WIDTH-1:0] fifoMem [RSP_DEPTH];
  logic             accept;
  logic             rdAccept;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits are counted from registered state only, so a pop frees its slot one cycle later.
  assign pending    = {1'b0, inflight} + {1'b0, fifoCount};
  assign reqReady_o = !rst_i && (pending < (CW+1)'(RSP_DEPTH));
  assign accept     = reqValid_i && reqReady_o;
  assign rdAccept   = accept && !reqWrite_i;

  assign memEn_o   = accept;
  assign memWr_o   = (accept && reqWrite_i) ? reqMask_i : '0;
  assign memAddr_o = reqAddr_i;
  assign memData_o = reqData_i;

  assign pipeExt    = {rdPipe, rdAccept};
  assign push       = rdPipe[DELAY-1];
  assign rspValid_o = (fifoCount != '0);
  assign pop        = rspValid_o && rspReady_i;
  assign rspData_o  = fifoMem[rdPtr];
  assign busy_o     = (pending != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdPipe    <= '0;
      inflight  <= '0;
      fifoCount <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
    end else begin
      rdPipe <= pipeExt[DELAY-1:0];
      case ({rdAccept, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + CW'(1);
        2'b01:   fifoCount <= fifoCount - CW'(1);
        default: fifoCount <= fifoCount;
      endcase
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      assert (!(push && !pop && (fifoCount == CW'(RSP_DEPTH))));
    end
  end

  // Data storage needs no reset; validity lives entirely in fifoCount.
  always_ff @(posedge clk_i) begin
    if (push) fifoMem[wrPtr] <= memData_i;
  end

endmodule

// File: tb/tb_mem_req_adapter.sv
// Bench for mem_req_adapter: two instances (DELAY=1 and DELAY=3) on behavioural masked RAMs,
// responses compared against a shadow-memory scoreboard.
module tb_mem_req_adapter;

  localparam int WIDTH  = 16;
  localparam int LENGTH = 32;
  localparam int MASK   = 2;
  localparam int DEPTH  = 4;
  localparam int AW     = 5;

  typedef struct {
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] want;
    logic             hadExp;
  } rsp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [1:0]            reqValid = '0;
  logic [1:0]            reqWrite = '0;
  logic [1:0]            rspReady = 2'b11;
  logic [1:0][AW-1:0]    reqAddr  = '0;
  logic [1:0][MASK-1:0]  reqMask  = '0;
  logic [1:0][WIDTH-1:0] reqData  = '0;
  logic [1:0]            reqReady, rspValid, memEn, busy;
  logic [1:0][AW-1:0]    memAddr;
  logic [1:0][MASK-1:0]  memWr;
  logic [1:0][WIDTH-1:0] rspData, memDataO, memDataI;

  mem_req_adapter #(.WIDTH(WIDTH), .LENGTH(LENGTH), .DELAY(1), .MASK(MASK), .RSP_DEPTH(DEPTH)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .reqValid_i(reqValid[0]), .reqReady_o(reqReady[0]), .reqWrite_i(reqWrite[0]),
    .reqAddr_i(reqAddr[0]), .reqMask_i(reqMask[0]), .reqData_i(reqData[0]),
    .rspValid_o(rspValid[0]), .rspReady_i(rspReady[0]), .rspData_o(rspData[0]),
    .memEn_o(memEn[0]), .memWr_o(memWr[0]), .memAddr_o(memAddr[0]), .memData_o(memDataO[0]),
    .memData_i(memDataI[0]), .busy_o(busy[0]));

  mem_req_adapter #(.WIDTH(WIDTH), .LENGTH(LENGTH), .DELAY(3), .MASK(MASK), .RSP_DEPTH(DEPTH)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i),
    .reqValid_i(reqValid[1]), .reqReady_o(reqReady[1]), .reqWrite_i(reqWrite[1]),
    .reqAddr_i(reqAddr[1]), .reqMask_i(reqMask[1]), .reqData_i(reqData[1]),
    .rspValid_o(rspValid[1]), .rspReady_i(rspReady[1]), .rspData_o(rspData[1]),
    .memEn_o(memEn[1]), .memWr_o(memWr[1]), .memAddr_o(memAddr[1]), .memData_o(memDataO[1]),
    .memData_i(memDataI[1]), .busy_o(busy[1]));

  // Behavioural masked RAMs, read latency 1 and 3.
  logic [WIDTH-1:0] ram [2][LENGTH];
  logic [WIDTH-1:0] ramPipe [2][3];
  always @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (memEn[i]) begin
        for (int c = 0; c < MASK; c++)
          if (memWr[i][c]) ram[i][memAddr[i]][c*8 +: 8] <= memDataO[i][c*8 +: 8];
        ramPipe[i][0] <= ram[i][memAddr[i]];
      end
      ramPipe[i][1] <= ramPipe[i][0];
      ramPipe[i][2] <= ramPipe[i][1];
    end
  end
  assign memDataI[0] = ramPipe[0][0];
  assign memDataI[1] = ramPipe[1][2];

  // Reference model: shadow memory updated at accept, expected read data queued in request order.
  logic [WIDTH-1:0] shadow [2][LENGTH];
  logic [WIDTH-1:0] expQ [2][$];
  rsp_t             resQ [2][$];
  int               maxOut [2];
  int               unstable = 0;
  logic [1:0]       prevStall = '0;
  logic [1:0][WIDTH-1:0] prevData;

  always @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_i) begin
        expQ[i].delete();
        prevStall[i] <= 1'b0;
      end else begin
        rsp_t r;
        if (prevStall[i] && (!rspValid[i] || rspData[i] !== prevData[i])) unstable <= unstable + 1;
        prevStall[i] <= rspValid[i] && !rspReady[i];
        prevData[i]  <= rspData[i];
        if (rspValid[i] && rspReady[i]) begin
          r.got = rspData[i];
          if (expQ[i].size() != 0) begin
            r.hadExp = 1'b1;
            r.want   = expQ[i].pop_front();
          end else begin
            r.hadExp = 1'b0;
            r.want   = '0;
          end
          resQ[i].push_back(r);
        end
        if (reqValid[i] && reqReady[i]) begin
          if (reqWrite[i]) begin
            for (int c = 0; c < MASK; c++)
              if (reqMask[i][c]) shadow[i][reqAddr[i]][c*8 +: 8] <= reqData[i][c*8 +: 8];
          end else begin
            expQ[i].push_back(shadow[i][reqAddr[i]]);
          end
        end
        if (expQ[i].size() > maxOut[i]) maxOut[i] <= expQ[i].size();
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int rdIdx [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge with valid still high.
  task automatic send(input int i, input bit wr, input int addr, input int mask, input int data);
    int n = 0;
    reqValid[i] = 1'b1;
    reqWrite[i] = wr;
    reqAddr[i]  = AW'(addr);
    reqMask[i]  = MASK'(mask);
    reqData[i]  = WIDTH'(data);
    while (!reqReady[i] && n < 200) begin
      if (n > 4) rspReady[i] = 1'b1;
      @(negedge clk_i);
      n++;
    end
    chk("send_wait", (n < 200), 1);
    @(negedge clk_i);
  endtask

  task automatic drainCheck(input int i, input string tag, input int expectN);
    int n = 0;
    rsp_t r;
    while (busy[i] && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_drain"}, (n < 2000), 1);
    @(negedge clk_i);
    chk({tag, "_count"}, resQ[i].size() - rdIdx[i], expectN);
    while (rdIdx[i] < resQ[i].size()) begin
      r = resQ[i][rdIdx[i]];
      rdIdx[i]++;
      chk({tag, "_expected"}, r.hadExp, 1'b1);
      chk({tag, "_data"}, r.got, r.want);
    end
  endtask

  task automatic waitValid(input int i, output int w);
    w = 0;
    while (!rspValid[i] && w < 50) begin
      @(negedge clk_i);
      w++;
    end
  endtask

  initial begin
    int w, acc, nR;
    int base;
    rdIdx[0] = 0; rdIdx[1] = 0;
    maxOut[0] = 0; maxOut[1] = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_reqReady", reqReady[i], 1'b0);
      chk("rst_rspValid", rspValid[i], 1'b0);
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_memEn", memEn[i], 1'b0);
      chk("rst_memWr", memWr[i], 2'b00);
    end
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < LENGTH; a++) send(i, 1'b1, a, 3, $urandom_range(0, 16'hffff));
      reqValid[i] = 1'b0;
      drainCheck(i, "init", 0);
    end

    // Full write then read-back, DELAY+1 cycles from the accept cycle.
    send(0, 1'b1, 3, 3, 16'hABCD);
    send(0, 1'b0, 3, 0, 0);
    reqValid[0] = 1'b0;
    waitValid(0, w);
    chk("t1_latency", w, 1);
    chk("t1_data", rspData[0], 16'hABCD);
    drainCheck(0, "t1", 1);

    // Partial mask, then a mask-0 write that must neither respond nor modify.
    send(0, 1'b1, 3, 1, 16'h1234);
    send(0, 1'b0, 3, 0, 0);
    reqValid[0] = 1'b0;
    waitValid(0, w);
    chk("t2_merge", rspData[0], 16'hAB34);
    @(negedge clk_i);
    send(0, 1'b1, 3, 0, 16'hFFFF);
    send(0, 1'b0, 3, 0, 0);
    reqValid[0] = 1'b0;
    waitValid(0, w);
    chk("t2_mask0", rspData[0], 16'hAB34);
    drainCheck(0, "t2", 2);

    // Credit limit with the consumer stalled.
    rspReady[0] = 1'b0;
    acc = 0;
    reqValid[0] = 1'b1; reqWrite[0] = 1'b0; reqAddr[0] = '0;
    for (int c = 0; c < 10; c++) begin
      if (reqReady[0]) acc++;
      @(negedge clk_i);
      reqAddr[0] = AW'(acc);
    end
    chk("t3_accepted", acc, 4);
    chk("t3_ready", reqReady[0], 1'b0);
    chk("t3_busy", busy[0], 1'b1);
    chk("t3_head", rspData[0], shadow[0][0]);
    rspReady[0] = 1'b1;
    for (int c = 0; c < 30 && acc < 6; c++) begin
      if (reqReady[0]) acc++;
      @(negedge clk_i);
      reqAddr[0] = AW'(acc);
    end
    reqValid[0] = 1'b0;
    chk("t3_all", acc, 6);
    drainCheck(0, "t3", 6);

    // Full FIFO released into a continuous read stream.
    rspReady[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 1'b0, $urandom_range(0, 31), 0, 0);
    reqAddr[0] = AW'($urandom_range(0, 31));
    chk("t4_full", reqReady[0], 1'b0);
    rspReady[0] = 1'b1;
    acc = 0; nR = 4;
    for (int c = 0; c < 16; c++) begin
      if (reqReady[0]) nR++;
      if (c >= 2 && reqReady[0]) acc++;
      @(negedge clk_i);
      reqAddr[0] = AW'($urandom_range(0, 31));
    end
    reqValid[0] = 1'b0;
    chk("t4_steady", acc, 14);
    drainCheck(0, "t4", nR);
    chk("t4_maxout", (maxOut[0] <= DEPTH), 1);

    // Reset with two reads in flight and one buffered (DELAY=3 instance).
    rspReady[1] = 1'b0;
    send(1, 1'b0, 7, 0, 0);
    reqValid[1] = 1'b0;
    waitValid(1, w);
    chk("t5_buffered", rspValid[1], 1'b1);
    send(1, 1'b0, 8, 0, 0);
    send(1, 1'b0, 9, 0, 0);
    reqValid[1] = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("t5_rspValid", rspValid[1], 1'b0);
    chk("t5_reqReady", reqReady[1], 1'b0);
    chk("t5_busy", busy[1], 1'b0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    rspReady[1] = 1'b1;
    base = resQ[1].size();
    for (int c = 0; c < 12; c++) @(negedge clk_i);
    chk("t5_nostale", resQ[1].size() - base, 0);
    chk("t5_idle", rspValid[1], 1'b0);
    rdIdx[1] = resQ[1].size();

    // DELAY=3 back-to-back reads.
    send(1, 1'b0, 0, 0, 0);
    chk("t6_w0", rspValid[1], 1'b0);
    send(1, 1'b0, 1, 0, 0);
    send(1, 1'b0, 2, 0, 0);
    chk("t6_w2", rspValid[1], 1'b0);
    send(1, 1'b0, 3, 0, 0);
    chk("t6_w3", rspValid[1], 1'b1);
    chk("t6_first", rspData[1], shadow[1][0]);
    reqValid[1] = 1'b0;
    drainCheck(1, "t6", 4);

    // Random mixed traffic with a randomly stalling consumer.
    nR = 0;
    for (int k = 0; k < 1000; k++) begin
      bit wr;
      rspReady[1] = ($urandom_range(0, 3) != 0);
      wr = 1'($urandom_range(0, 1));
      if (!wr) nR++;
      send(1, wr, $urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 16'hffff));
      if ($urandom_range(0, 4) == 0) begin
        reqValid[1] = 1'b0;
        @(negedge clk_i);
      end
    end
    reqValid[1] = 1'b0;
    rspReady[1] = 1'b1;
    drainCheck(1, "rand", nR);
    chk("rand_maxout", (maxOut[1] <= DEPTH), 1);
    chk("hold_stable", unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
